// File: rtl/mdc_minor2_param.sv
// mdc_minor2_param: loads an NxN matrix of Hamming-coded words (single-bit
// correction per word), then computes every contiguous 2x2 minor serially
// on one shared multiplier pair and presents them packed with a one-cycle strobe.
module mdc_minor2_param #(
  parameter int N  = 4,
  parameter int DW = 11,
  parameter int PW = 4,
  localparam int CW = DW + PW,
  localparam int K  = (N - 1) * (N - 1),
  localparam int RW = 2 * DW + 1,
  localparam int EW = $clog2(N * N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [CW-1:0]   in_data,
  output logic            out_valid,
  output logic [K*RW-1:0] out_data,
  output logic [EW-1:0]   err_cnt
);
  localparam int NN  = N * N;
  localparam int IW  = $clog2(NN);
  localparam int KW  = $clog2(K + 1);
  localparam int RCW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]        syn;
  logic [CW-1:0]        fixed;
  logic signed [DW-1:0] word;
  logic                 corr;
  int unsigned          j;

  logic signed [DW-1:0] mat [NN];
  logic signed [RW-1:0] res [K];
  logic [EW-1:0]        cnt_q;
  logic [EW-1:0]        errs_q;
  logic [KW-1:0]        k_q;
  logic [RCW-1:0]       r_q, c_q;
  logic                 last_word;

  logic [IW-1:0]          base;
  logic signed [DW-1:0]   a_rc, a_rc1, a_r1c, a_r1c1;
  logic signed [2*DW-1:0] p_main, p_anti;
  logic signed [RW-1:0]   minor;
  logic [K*RW-1:0]        packed_res;

  // Syndrome: XOR of the Hamming positions of all set bits (position p is bit CW-p).
  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p <= CW; p++)
      if (in_data[CW-p]) syn ^= PW'(p);
  end

  // Flip the bit named by the syndrome, then gather data bits; lowest data position is the MSB.
  always_comb begin
    fixed = in_data;
    for (int unsigned p = 1; p <= CW; p++)
      if (syn == PW'(p)) fixed[CW-p] = ~fixed[CW-p];
    word = '0;
    j    = DW;
    for (int unsigned p = 1; p <= CW; p++)
      if ((p & (p - 1)) != 0) begin
        word[j-1] = fixed[CW-p];
        j         = j - 1;
      end
    corr = (syn != '0);
  end

  assign last_word = in_valid && (cnt_q == EW'(NN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: OUT spends two cycles, raising the strobe then clearing it on the way to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_LOAD;
      S_LOAD:  if (last_word) state_d = S_CALC;
      S_CALC:  if (k_q == KW'(K - 1)) state_d = S_OUT;
      S_OUT:   if (out_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand select for minor (r,c) and the shared multiplier pair.
  always_comb begin
    base   = IW'(r_q) * IW'(N) + IW'(c_q);
    a_rc   = mat[base];
    a_rc1  = mat[base + IW'(1)];
    a_r1c  = mat[base + IW'(N)];
    a_r1c1 = mat[base + IW'(N + 1)];
    p_main = (2*DW)'(a_rc) * (2*DW)'(a_r1c1);
    p_anti = (2*DW)'(a_rc1) * (2*DW)'(a_r1c);
    minor  = RW'(p_main) - RW'(p_anti);
  end

  // Load storage, step the minor index, count corrections and drive the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      errs_q    <= '0;
      k_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < NN; i++) mat[i] <= '0;
      for (int unsigned i = 0; i < K; i++)  res[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid <= 1'b0;
          errs_q    <= '0;
          k_q       <= '0;
          r_q       <= '0;
          c_q       <= '0;
          if (in_valid) begin
            mat[0] <= word;
            cnt_q  <= EW'(1);
            errs_q <= EW'(corr);
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mat[IW'(cnt_q)] <= word;
            cnt_q           <= cnt_q + EW'(1);
            errs_q          <= errs_q + EW'(corr);
          end
        end
        S_CALC: begin
          res[k_q] <= minor;
          k_q      <= k_q + KW'(1);
          if (c_q == RCW'(N - 2)) begin
            c_q <= '0;
            r_q <= r_q + RCW'(1);
          end else begin
            c_q <= c_q + RCW'(1);
          end
        end
        S_OUT:   out_valid <= ~out_valid;
        default: out_valid <= 1'b0;
      endcase
    end
  end

  // Pack minor k at the MSB end for k=0.
  always_comb begin
    packed_res = '0;
    for (int unsigned i = 0; i < K; i++)
      packed_res[(K-1-i)*RW +: RW] = res[i];
  end

  assign out_data = out_valid ? packed_res : '0;
  assign err_cnt  = out_valid ? errs_q : '0;

endmodule

// File: tb/tb_mdc_minor2_param.sv
// Directed and randomised bench for mdc_minor2_param at N=4, DW=11, PW=4.
`timescale 1ns/1ps
module tb_mdc_minor2_param;
  localparam int N   = 4;
  localparam int DW  = 11;
  localparam int PW  = 4;
  localparam int CW  = 15;
  localparam int K   = 9;
  localparam int RW  = 23;
  localparam int KRW = K * RW;
  localparam int EW  = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [CW-1:0]  in_data = '0;
  logic           out_valid;
  logic [KRW-1:0] out_data;
  logic [EW-1:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int            vals [16];
  logic [CW-1:0] cw_arr [16];

  mdc_minor2_param #(.N(N), .DW(DW), .PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Hamming encoder: data bits in non-power-of-two positions (MSB first), even parity.
  function automatic logic [CW-1:0] encode(input int v);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int            jj;
    logic          par;
    c  = '0;
    d  = v[DW-1:0];
    jj = DW - 1;
    for (int p = 1; p <= CW; p++)
      if ((p & (p - 1)) != 0) begin
        c[CW-p] = d[jj];
        jj--;
      end
    for (int i = 0; i < PW; i++) begin
      par = 1'b0;
      for (int p = 1; p <= CW; p++)
        if ((((p >> i) & 1) == 1) && (p != (1 << i))) par ^= c[CW-p];
      c[CW-(1<<i)] = par;
    end
    return c;
  endfunction

  function automatic logic [KRW-1:0] model_minors();
    logic [KRW-1:0] e;
    int             m;
    logic [31:0]    mu;
    e = '0;
    for (int k = 0; k < K; k++) begin
      int r;
      int c;
      r  = k / (N - 1);
      c  = k % (N - 1);
      m  = vals[r*N+c] * vals[(r+1)*N+c+1] - vals[r*N+c+1] * vals[(r+1)*N+c];
      mu = m;
      e[(K-1-k)*RW +: RW] = mu[RW-1:0];
    end
    return e;
  endfunction

  task automatic build_words();
    for (int i = 0; i < 16; i++) cw_arr[i] = encode(vals[i]);
  endtask

  task automatic send(input bit hold, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && ($urandom_range(0, 5) == 0)) begin
        in_valid = 1'b0;
        in_data  = '1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = cw_arr[i];
      @(posedge clk);
      #1;
    end
    if (hold) begin
      in_data = 15'h1234;
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic wait_result(input string tag, input logic [KRW-1:0] exp_d, input int exp_e);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = out_valid;
    end
    chk({tag, "_latency"}, cyc, K + 1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_errcnt"}, err_cnt, exp_e);
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {out_valid, err_cnt, out_data}, 0);
  endtask

  initial begin
    logic [KRW-1:0] id_exp, ext_exp, neg_exp, exp_a, exp_b;
    int nerr;
    int seen_any;

    id_exp = '0;
    id_exp[8*RW] = 1'b1;
    id_exp[4*RW] = 1'b1;
    id_exp[0]    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, err_cnt, out_data}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_release", {out_valid, err_cnt, out_data}, 0);

    for (int i = 0; i < 16; i++) cw_arr[i] = (i % 5 == 0) ? 15'h6881 : 15'h0000;

    // Seven words, then an asynchronous reset mid-LOAD.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = cw_arr[i];
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_reset", {out_valid, err_cnt, out_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_any = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_any = 1;
    end
    chk("abort_no_output", seen_any, 0);

    send(1'b0, 1'b0);
    wait_result("identity", id_exp, 0);

    for (int i = 0; i < 16; i++) cw_arr[i] = 15'h6881;
    send(1'b0, 1'b0);
    wait_result("all_ones", '0, 0);

    for (int i = 0; i < 16; i++) cw_arr[i] = (i % 5 == 0) ? 15'h6881 : 15'h0000;
    cw_arr[0]  = 15'h6801;
    cw_arr[15] = 15'h6880;
    send(1'b0, 1'b0);
    wait_result("corrected", id_exp, 2);

    // Extremes: minor0 = 1024*1024 + 1024*1023, minor4 = 1024*1024, minor8 = 1024*1024 - 1023*1023.
    vals = '{-1024, -1024, 0, 0,
              1023, -1024, 0, 0,
                 0,     0, -1024, 1023,
                 0,     0,  1023, -1024};
    build_words();
    ext_exp = '0;
    ext_exp[8*RW +: RW] = 23'd2096128;
    ext_exp[4*RW +: RW] = 23'd1048576;
    ext_exp[0*RW +: RW] = 23'd2047;
    send(1'b0, 1'b0);
    wait_result("extreme_pos", ext_exp, 0);

    // minor0 = -1024*1023 - (-1024)*(-1024) = -2096128, i.e. 0x600400 in 23 bits.
    vals = '{-1024, -1024, 0, 0,
             -1024,  1023, 0, 0,
                 0,     0, 0, 0,
                 0,     0, 0, 0};
    build_words();
    neg_exp = '0;
    neg_exp[8*RW +: RW] = 23'h600400;
    send(1'b0, 1'b0);
    wait_result("extreme_neg", neg_exp, 0);

    // Back-to-back with in_valid held high through A's calculation.
    for (int i = 0; i < 16; i++) vals[i] = int'($urandom_range(0, 2047)) - 1024;
    build_words();
    exp_a = model_minors();
    send(1'b1, 1'b0);
    wait_result("b2b_a", exp_a, 0);
    for (int i = 0; i < 16; i++) vals[i] = int'($urandom_range(0, 2047)) - 1024;
    build_words();
    exp_b = model_minors();
    send(1'b0, 1'b0);
    wait_result("b2b_b", exp_b, 0);

    // Random small matrices with occasional single-bit errors and input gaps.
    for (int t = 0; t < 200; t++) begin
      nerr = 0;
      for (int i = 0; i < 16; i++) vals[i] = int'($urandom_range(1, 9));
      build_words();
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 3) == 0) begin
          int b;
          b = int'($urandom_range(0, CW - 1));
          cw_arr[i][b] = ~cw_arr[i][b];
          nerr++;
        end
      send(1'b0, 1'b1);
      wait_result("rand", model_minors(), nerr);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
